// File: rtl/key_window_scheduler.sv
// Presents one of three stored keys to a locked core in phase-aligned windows.
// All state advances on the falling edge, in lockstep with the core's window counter.
module key_window_scheduler #(
  parameter int unsigned KEY_W   = 9,
  parameter int unsigned WIN_LEN = 9,
  parameter int unsigned PH_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [1:0]       cfg_idx,
  input  logic [KEY_W-1:0] cfg_key,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic [KEY_W-1:0] key_out,
  output logic [1:0]       win_idx,
  output logic [PH_W-1:0]  phase,
  output logic             wrap,
  output logic             armed,
  output logic             running
);

  localparam int unsigned    PERIOD  = 3 * WIN_LEN;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_WIN1 = PH_W'(WIN_LEN);
  localparam logic [PH_W-1:0] PH_WIN2 = PH_W'(2 * WIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PEND  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [KEY_W-1:0] key0_q, key0_d, key1_q, key1_d, key2_q, key2_d;
  logic [2:0]       mask_q, mask_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wr_ok;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      key0_q    <= '0;
      key1_q    <= '0;
      key2_q    <= '0;
      mask_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      key0_q    <= key0_d;
      key1_q    <= key1_d;
      key2_q    <= key2_d;
      mask_q    <= mask_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state: free-running phase, key bank writes, and the run-control FSM.
  always_comb begin
    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    key0_d    = key0_q;
    key1_d    = key1_q;
    key2_d    = key2_q;
    mask_d    = mask_q;
    state_d   = state_q;
    wr_ok     = cfg_valid && cfg_ready && (cfg_idx != 2'd3);
    cfg_err_d = cfg_valid && !wr_ok;

    if (wr_ok) begin
      case (cfg_idx)
        2'd0:    begin key0_d = cfg_key; mask_d[0] = 1'b1; end
        2'd1:    begin key1_d = cfg_key; mask_d[1] = 1'b1; end
        2'd2:    begin key2_d = cfg_key; mask_d[2] = 1'b1; end
        default: ;
      endcase
    end

    // stop always wins; PEND only enters RUN on the edge where phase returns to 0
    case (state_q)
      S_IDLE:  if (&mask_d) state_d = S_ARMED;
      S_ARMED: if (start && !stop) state_d = S_PEND;
      S_PEND: begin
        if (stop) state_d = S_ARMED;
        else if (phase_q == PH_LAST) state_d = S_RUN;
      end
      S_RUN:   if (stop) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded directly from state, phase and bank so keys track the window with no lag.
  always_comb begin
    cfg_ready = (state_q == S_IDLE) || (state_q == S_ARMED);
    cfg_err   = cfg_err_q;
    phase     = phase_q;
    wrap      = (phase_q == PH_LAST);
    armed     = &mask_q;
    running   = (state_q == S_RUN);
    win_idx   = 2'd2;
    if (phase_q < PH_WIN1)      win_idx = 2'd0;
    else if (phase_q < PH_WIN2) win_idx = 2'd1;
    key_out = '0;
    if (state_q == S_RUN) begin
      case (win_idx)
        2'd0:    key_out = key0_q;
        2'd1:    key_out = key1_q;
        default: key_out = key2_q;
      endcase
    end
  end

endmodule

// File: tb/tb_key_window_scheduler.sv
// Bench for key_window_scheduler: directed scenarios plus random traffic,
// every output compared each cycle against a behavioural model.
module tb_key_window_scheduler;

  localparam int unsigned KEY_W   = 9;
  localparam int unsigned WIN_LEN = 9;
  localparam int unsigned PH_W    = 5;
  localparam int PERIOD = 3 * WIN_LEN;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_PEND  = 2;
  localparam int M_RUN   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [1:0]       cfg_idx = 2'd0;
  logic [KEY_W-1:0] cfg_key = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_ready, cfg_err, wrap, armed, running;
  logic [KEY_W-1:0] key_out;
  logic [1:0]       win_idx;
  logic [PH_W-1:0]  phase;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // model state
  int m_phase = 0;
  int m_mode  = M_IDLE;
  int m_key [3] = '{0, 0, 0};
  bit m_ld  [3] = '{0, 0, 0};
  bit m_err = 1'b0;

  key_window_scheduler #(.KEY_W(KEY_W), .WIN_LEN(WIN_LEN), .PH_W(PH_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .start(start), .stop(stop),
    .key_out(key_out), .win_idx(win_idx), .phase(phase), .wrap(wrap),
    .armed(armed), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    return m_ld[0] && m_ld[1] && m_ld[2];
  endfunction

  function automatic int m_key_out();
    if (m_mode != M_RUN) return 0;
    return m_key[m_phase / WIN_LEN];
  endfunction

  // Behavioural model, advanced on the same falling edge as the design.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_mode  = M_IDLE;
      for (int i = 0; i < 3; i++) begin m_key[i] = 0; m_ld[i] = 1'b0; end
      m_err = 1'b0;
    end else begin
      int  old_phase;
      bit  ready, acc;
      old_phase = m_phase;
      ready = (m_mode == M_IDLE) || (m_mode == M_ARMED);
      acc   = cfg_valid && ready && (int'(cfg_idx) < 3);
      m_err = cfg_valid && !acc;
      if (acc) begin
        m_key[int'(cfg_idx)] = int'(cfg_key);
        m_ld[int'(cfg_idx)]  = 1'b1;
      end
      if (m_mode == M_IDLE) begin
        if (m_full()) m_mode = M_ARMED;
      end else if (stop) begin
        m_mode = M_ARMED;
      end else if (m_mode == M_ARMED && start) begin
        m_mode = M_PEND;
      end else if (m_mode == M_PEND && old_phase == PERIOD - 1) begin
        m_mode = M_RUN;
      end
      m_phase = (old_phase + 1) % PERIOD;
    end
  end

  // Compare every output on the rising edge, midway between design updates.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("key_out",   int'(key_out),   m_key_out());
      chk("phase",     int'(phase),     m_phase);
      chk("win_idx",   int'(win_idx),   m_phase / WIN_LEN);
      chk("wrap",      int'(wrap),      int'(m_phase == PERIOD - 1));
      chk("armed",     int'(armed),     int'(m_full()));
      chk("running",   int'(running),   int'(m_mode == M_RUN));
      chk("cfg_ready", int'(cfg_ready), int'(m_mode == M_IDLE || m_mode == M_ARMED));
      chk("cfg_err",   int'(cfg_err),   int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while (m_phase != p && k < 4 * PERIOD) begin
      cyc(1);
      k++;
    end
    n_tests++;
    if (m_phase != p) begin
      n_fail++;
      $display("FAIL wait_phase: timed out waiting for phase %0d (at %0d)", p, m_phase);
    end
  endtask

  task automatic wr(input int idx, input int key);
    cfg_valid = 1'b1;
    cfg_idx   = 2'(idx);
    cfg_key   = KEY_W'(key);
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_key", int'(key_out), 0);
    chk("rst_running", int'(running), 0);

    // load the three keys
    wr(0, 382);
    wr(1, 461);
    chk("armed_2of3", int'(armed), 0);
    wr(2, 214);
    chk("armed_3of3", int'(armed), 1);
    chk("no_err_load", int'(cfg_err), 0);

    // start at phase 5, run begins at phase 0
    wait_phase(5);
    pulse_start();
    chk("pend_running", int'(running), 0);
    chk("pend_ready", int'(cfg_ready), 0);
    wait_phase(0);
    chk("run_p0_running", int'(running), 1);
    chk("run_p0_key", int'(key_out), 382);
    wait_phase(9);
    chk("run_p9_key", int'(key_out), 461);
    wait_phase(18);
    chk("run_p18_key", int'(key_out), 214);

    // illegal writes
    wr(3, 77);
    chk("err_idx3", int'(cfg_err), 1);
    cyc(1);
    chk("err_idx3_clear", int'(cfg_err), 0);
    wr(1, 5);
    chk("err_busy", int'(cfg_err), 1);
    cyc(1);
    chk("err_busy_clear", int'(cfg_err), 0);
    wait_phase(9);
    chk("bank_unchanged", int'(key_out), 461);

    // stop at phase 12
    wait_phase(12);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_key", int'(key_out), 0);
    chk("stop_running", int'(running), 0);
    chk("stop_ready", int'(cfg_ready), 1);

    // simultaneous start and stop resolves to stop
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    cyc(2 * PERIOD);
    chk("ss_running", int'(running), 0);
    chk("ss_ready", int'(cfg_ready), 1);

    // reset during RUN at phase 20
    pulse_start();
    wait_phase(0);
    chk("rerun_key", int'(key_out), 382);
    wait_phase(20);
    rst = 1'b1;
    #1;
    chk("rstrun_key", int'(key_out), 0);
    chk("rstrun_phase", int'(phase), 0);
    chk("rstrun_armed", int'(armed), 0);
    cyc(1);
    rst = 1'b0;
    pulse_start();
    cyc(2 * PERIOD);
    chk("rst_start_ignored", int'(running), 0);

    // partial load then start
    wr(0, 100);
    wr(2, 300);
    pulse_start();
    cyc(2 * PERIOD);
    chk("partial_armed", int'(armed), 0);
    chk("partial_key", int'(key_out), 0);
    chk("partial_ready", int'(cfg_ready), 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cfg_valid = ($urandom % 3) == 0;
      cfg_idx   = 2'($urandom % 4);
      cfg_key   = KEY_W'($urandom);
      start     = ($urandom % 6) == 0;
      stop      = ($urandom % 50) == 0;
      if (($urandom % 500) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end else begin
        cyc(1);
      end
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
